pe_array_seq: RTL
=================

# pe_array_seq

Tile sequencer directly upstream of `pe_array`. On `start`, it walks the full output matrix (OA_H × OA_W) in MAC_NUM-row tiles and does the following for each tile:
- reads one activation word (MAC_NUM lanes) and one broadcast weight per inner-dimension step from synchronous buffers;
- drives the PE operand and control ports;
- issues the accumulator clear;
- captures `PE_result_out` into the output buffer.

It replaces the hand-written operand loop used at bench level with synthesizable control.

## Interface
Parameters:
- MAC_NUM, 10, PE lanes (IA_H must be a multiple of MAC_NUM)
- BW_ACT, 8, activation/result lane width
- BW_WET, 8, weight width
- IA_H, 100, activation rows
- IA_W, 150, inner dimension (weight rows)
- OA_W, 16, output columns
- RES_LAT, 2, cycles from the PE_clear_acc cycle to valid PE_result_out (≥1)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  run request, sampled only in IDLE
- shift_num  in  8  result shift, latched at start
- busy  out  1  run in progress
- done  out  1  one-cycle pulse after last write
- act_rd_en  out  1  activation buffer read
- act_rd_addr  out  clog2(IA_H/MAC_NUM*IA_W)  address j*IA_W+i
- act_rd_data  in  MAC_NUM*BW_ACT  lane n at [n*BW_ACT +: BW_ACT], valid 1 cycle after read
- wet_rd_en  out  1  weight buffer read
- wet_rd_addr  out  clog2(IA_W*OA_W)  address i*OA_W+m
- wet_rd_data  in  BW_WET  valid 1 cycle after read
- PE_mac_enable  out  1  to pe_array
- PE_clear_acc  out  1  to pe_array
- PE_act_in  out  MAC_NUM×BW_ACT  to pe_array, lane n = act_rd_data lane n
- PE_wet_in  out  BW_WET  to pe_array
- PE_res_shift_num  out  8  latched shift_num
- PE_result_out  in  MAC_NUM×BW_ACT  from pe_array
- out_wr_en  out  1  output buffer write
- out_wr_addr  out  clog2(IA_H/MAC_NUM*OA_W)  address j*OA_W+m
- out_wr_data  out  MAC_NUM*BW_ACT  lane n = PE_result_out[n]

## Operation
- FSM states: IDLE → FETCH → DRAIN → CLEAR → WAIT → WRITE, then either FETCH (next tile) or IDLE.
- Loop order: m (0..OA_W-1) is the outer loop; j (0..IA_H/MAC_NUM-1) is the inner loop; i (0..IA_W-1) is walked within the tile.
- FETCH (IA_W cycles): act_rd_en and wet_rd_en are high; addresses are issued for i = 0..IA_W-1.
- Operand cycles: PE_act_in and PE_wet_in pass through the read data, one cycle after each address. The operand cycles therefore span the last IA_W-1 FETCH cycles plus DRAIN.
- CLEAR (1 cycle): PE_clear_acc=1; PE_act_in and PE_wet_in are forced to 0. In every other cycle PE_clear_acc=0.
- WAIT: lasts RES_LAT-1 cycles; no reads are issued.
- WRITE (1 cycle): out_wr_en=1 and PE_result_out is sampled as out_wr_data.
  - If (m,j) is the last tile, the FSM returns to IDLE and done pulses in the next cycle.
  - Otherwise j increments; at wrap, j returns to 0 and m increments.
- PE_mac_enable is high in every state except IDLE.
- start while busy is ignored. shift_num changes mid-run are ignored.
- Outside FETCH, read enables are 0. Outside WRITE, out_wr_en is 0.

## Timing
- Reset (asynchronous, immediate):
  - FSM returns to IDLE; counters i, j, m are cleared.
  - All outputs are 0: busy, done, enables, PE_clear_acc, PE_mac_enable, operand buses, PE_res_shift_num, addresses, write data.
- Start: start=1 sampled high in IDLE at edge T makes cycle T+1 FETCH(i=0), with busy=1.
- Tile length: IA_W+2+RES_LAT cycles. The clear cycle is at tile offset IA_W+1; WRITE is at offset IA_W+1+RES_LAT.
- Run length: total = (IA_H/MAC_NUM)·OA_W·(IA_W+2+RES_LAT). The default configuration takes 24640 cycles.
- busy stays high from the first FETCH cycle through the final WRITE cycle inclusive.
- done is high for exactly the one cycle after the final WRITE, with busy=0 in that cycle. start asserted in that same cycle is accepted.
- Consecutive tiles run back-to-back with no idle gap.
- Reset mid-run: no further reads or writes occur. Any partial tile is discarded and done is not pulsed.

## Test plan
- Reset: assert reset_n=0 mid-clock → all outputs read 0 before the next edge; busy=0 and done=0 after release.
- Small config (MAC_NUM=2, IA_H=4, IA_W=3, OA_W=2, RES_LAT=2) with behavioural SRAMs and a behavioural PE:
  - act_rd_addr sequence 0,1,2, then 3,4,5 (j=1), then 0,1,2 (m=1);
  - wet_rd_addr sequence 0,2,4, then 0,2,4, then 1,3,5;
  - out_wr_addr sequence 0,2,1,3;
  - each tile is 7 cycles; done at cycle 29 after start.
- Clear alignment (small config): PE_clear_acc is high exactly at tile offset 4 with PE_act_in=0 and PE_wet_in=0; out_wr_en is high at offset 6 and captures PE_result_out.
- Full default run against `pe_array` with `input_act_bin.txt`, `weight_bin.txt` and `reference_output_bin.txt`, shift_num=8 → 0 mismatches over 100×16 outputs; done after 24640 busy cycles.
- start pulses plus a shift_num change from 8→3 during busy → no restart; PE_res_shift_num stays 8.
- Reset during tile (m=0,j=1) of the small config → no writes after reset; a fresh start then reproduces the full address sequence from 0. Additionally, start held high in the done cycle → a second run begins with no gap.

Source files
------------

// File: rtl/pe_array_seq.sv
// Tile sequencer for pe_array: streams activation/weight operands per output tile,
// clears the accumulators and writes each tile result to the output buffer.
module pe_array_seq #(
    parameter int MAC_NUM = 10,
    parameter int BW_ACT  = 8,
    parameter int BW_WET  = 8,
    parameter int IA_H    = 100,
    parameter int IA_W    = 150,
    parameter int OA_W    = 16,
    parameter int RES_LAT = 2
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic                                     start,
    input  logic [7:0]                               shift_num,
    output logic                                     busy,
    output logic                                     done,
    output logic                                     act_rd_en,
    output logic [$clog2(IA_H/MAC_NUM*IA_W)-1:0]     act_rd_addr,
    input  logic [MAC_NUM*BW_ACT-1:0]                act_rd_data,
    output logic                                     wet_rd_en,
    output logic [$clog2(IA_W*OA_W)-1:0]             wet_rd_addr,
    input  logic [BW_WET-1:0]                        wet_rd_data,
    output logic                                     PE_mac_enable,
    output logic                                     PE_clear_acc,
    output logic [MAC_NUM*BW_ACT-1:0]                PE_act_in,
    output logic [BW_WET-1:0]                        PE_wet_in,
    output logic [7:0]                               PE_res_shift_num,
    input  logic [MAC_NUM*BW_ACT-1:0]                PE_result_out,
    output logic                                     out_wr_en,
    output logic [$clog2(IA_H/MAC_NUM*OA_W)-1:0]     out_wr_addr,
    output logic [MAC_NUM*BW_ACT-1:0]                out_wr_data
);

    localparam int TILES_J = IA_H / MAC_NUM;
    localparam int ACT_AW  = $clog2(TILES_J * IA_W);
    localparam int WET_AW  = $clog2(IA_W * OA_W);
    localparam int OUT_AW  = $clog2(TILES_J * OA_W);
    localparam int IW      = (IA_W > 1) ? $clog2(IA_W) : 1;
    localparam int JW      = (TILES_J > 1) ? $clog2(TILES_J) : 1;
    localparam int MW      = (OA_W > 1) ? $clog2(OA_W) : 1;
    localparam int CW      = (RES_LAT > 2) ? $clog2(RES_LAT - 1) : 1;

    localparam logic [IW-1:0] I_LAST = IW'(IA_W - 1);
    localparam logic [JW-1:0] J_LAST = JW'(TILES_J - 1);
    localparam logic [MW-1:0] M_LAST = MW'(OA_W - 1);
    localparam logic [CW-1:0] C_LAST = CW'((RES_LAT >= 2) ? RES_LAT - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DRAIN, S_CLEAR, S_WAIT, S_WRITE
    } state_e;

    state_e              state_q;
    logic [IW-1:0]       i_q;
    logic [JW-1:0]       j_q, j_d;
    logic [MW-1:0]       m_q, m_d;
    logic [CW-1:0]       wait_q;
    logic                busy_q, done_q, rd_en_q, opnd_vld_q, clear_q, wr_en_q;
    logic [ACT_AW-1:0]   act_addr_q;
    logic [WET_AW-1:0]   wet_addr_q;
    logic [OUT_AW-1:0]   out_addr_q;
    logic [7:0]          shift_q;
    logic                last_j, last_tile;

    assign last_j    = (j_q == J_LAST);
    assign last_tile = last_j && (m_q == M_LAST);

    // Next tile coordinates: j is the inner loop, m advances when j wraps.
    always_comb begin
        j_d = last_j ? '0 : j_q + JW'(1);
        m_d = last_j ? m_q + MW'(1) : m_q;
    end

    // NOTE: sequential state uses non-blocking assignments only, and every register
    // (including addresses and control outputs) is cleared by the async reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            j_q        <= '0;
            m_q        <= '0;
            wait_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_en_q    <= 1'b0;
            opnd_vld_q <= 1'b0;
            clear_q    <= 1'b0;
            wr_en_q    <= 1'b0;
            act_addr_q <= '0;
            wet_addr_q <= '0;
            out_addr_q <= '0;
            shift_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q    <= S_FETCH;
                        busy_q     <= 1'b1;
                        rd_en_q    <= 1'b1;
                        i_q        <= '0;
                        j_q        <= '0;
                        m_q        <= '0;
                        act_addr_q <= '0;
                        wet_addr_q <= '0;
                        shift_q    <= shift_num;
                    end
                end
                S_FETCH: begin
                    // Each issued read returns data next cycle, which is an operand cycle.
                    opnd_vld_q <= 1'b1;
                    if (i_q == I_LAST) begin
                        state_q <= S_DRAIN;
                        rd_en_q <= 1'b0;
                    end else begin
                        i_q        <= i_q + IW'(1);
                        act_addr_q <= act_addr_q + ACT_AW'(1);
                        wet_addr_q <= wet_addr_q + WET_AW'(OA_W);
                    end
                end
                S_DRAIN: begin
                    opnd_vld_q <= 1'b0;
                    clear_q    <= 1'b1;
                    state_q    <= S_CLEAR;
                end
                S_CLEAR: begin
                    clear_q <= 1'b0;
                    wait_q  <= '0;
                    if (RES_LAT == 1) begin
                        state_q    <= S_WRITE;
                        wr_en_q    <= 1'b1;
                        out_addr_q <= OUT_AW'(j_q) * OUT_AW'(OA_W) + OUT_AW'(m_q);
                    end else begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wait_q == C_LAST) begin
                        state_q    <= S_WRITE;
                        wr_en_q    <= 1'b1;
                        out_addr_q <= OUT_AW'(j_q) * OUT_AW'(OA_W) + OUT_AW'(m_q);
                    end else begin
                        wait_q <= wait_q + CW'(1);
                    end
                end
                S_WRITE: begin
                    wr_en_q <= 1'b0;
                    if (last_tile) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        state_q    <= S_FETCH;
                        rd_en_q    <= 1'b1;
                        i_q        <= '0;
                        j_q        <= j_d;
                        m_q        <= m_d;
                        act_addr_q <= ACT_AW'(j_d) * ACT_AW'(IA_W);
                        wet_addr_q <= WET_AW'(m_d);
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // NOTE: operand and write-data buses are registered-flag gates over buffer/PE data,
    // giving same-cycle pass-through while staying zero whenever the flag is low.
    assign PE_act_in        = opnd_vld_q ? act_rd_data : '0;
    assign PE_wet_in        = opnd_vld_q ? wet_rd_data : '0;
    assign out_wr_data      = wr_en_q ? PE_result_out : '0;

    assign busy             = busy_q;
    assign done             = done_q;
    assign act_rd_en        = rd_en_q;
    assign wet_rd_en        = rd_en_q;
    assign act_rd_addr      = act_addr_q;
    assign wet_rd_addr      = wet_addr_q;
    assign PE_mac_enable    = busy_q;
    assign PE_clear_acc     = clear_q;
    assign PE_res_shift_num = shift_q;
    assign out_wr_en        = wr_en_q;
    assign out_wr_addr      = out_addr_q;

endmodule
